pipe_control_unit: RTL

- Decode stage that sits directly upstream of the 5-stage datapath.
- Consumes the instruction-register fields (opcode, rs1_rs, rs2_rd, rd) and produces the datapath control strobes.
- Owns RAW-hazard stalling through a destination scoreboard, since the datapath has no forwarding.
- Owns branch/jump bubble insertion through a small FSM.

---
 rtl/pipe_ctrl_pkg.sv | 100 ++++++++++
 rtl/pipe_control_unit_if.sv | 29 ++
 rtl/hazard_scoreboard.sv | 46 ++++
 rtl/pipe_control_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Decode constants, output encodings, FSM state codes and the opcode decoder
// shared by pipe_control_unit and its scoreboard.
package pipe_ctrl_pkg;

    localparam logic [5:0] OpNop  = 6'h00;
    localparam logic [5:0] AluRLo = 6'h01;
    localparam logic [5:0] AluRHi = 6'h0F;
    localparam logic [5:0] AluILo = 6'h10;
    localparam logic [5:0] AluIHi = 6'h17;
    localparam logic [5:0] OpSli  = 6'h18;
    localparam logic [5:0] OpSri  = 6'h19;
    localparam logic [5:0] OpLd   = 6'h20;
    localparam logic [5:0] OpSt   = 6'h21;
    localparam logic [5:0] OpMov  = 6'h22;
    localparam logic [5:0] OpBr   = 6'h30;
    localparam logic [5:0] OpJ    = 6'h31;

    localparam logic [1:0] JbSeq    = 2'b00;
    localparam logic [1:0] JbBranch = 2'b01;
    localparam logic [1:0] JbJump   = 2'b10;

    localparam logic [1:0] MrAlu  = 2'b00;
    localparam logic [1:0] MrMem  = 2'b01;
    localparam logic [1:0] MrMove = 2'b10;

    localparam logic [1:0] DestNone = 2'b00;
    localparam logic [1:0] DestRd   = 2'b01;
    localparam logic [1:0] DestRs2  = 2'b10;

    localparam logic [1:0] StRun   = 2'b00;
    localparam logic [1:0] StFlush = 2'b01;
    localparam logic [1:0] StHalt  = 2'b10;

    typedef struct packed {
        logic       dm_write;
        logic       rf_dest_addr;
        logic       rf_write;
        logic       sli_sri;
        logic       imm_instr;
        logic [1:0] jump_or_branch;
        logic [1:0] mem_to_reg;
        logic [1:0] dest_sel;
        logic       use_rs1;
        logic       use_rs2;
        logic       illegal;
    } ctrl_t;

    // Unknown opcodes decode to an all-zero bubble with only the illegal flag set.
    function automatic ctrl_t decode(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        if (op >= AluRLo && op <= AluRHi) begin
            c.rf_write = 1'b1;
            c.dest_sel = DestRd;
            c.use_rs1  = 1'b1;
            c.use_rs2  = 1'b1;
        end else if (op >= AluILo && op <= AluIHi) begin
            c.rf_write  = 1'b1;
            c.imm_instr = 1'b1;
            c.dest_sel  = DestRs2;
            c.use_rs1   = 1'b1;
        end else begin
            case (op)
                OpSli, OpSri: begin
                    c.rf_write = 1'b1;
                    c.sli_sri  = 1'b1;
                    c.dest_sel = DestRs2;
                    c.use_rs1  = 1'b1;
                end
                OpLd: begin
                    c.rf_write   = 1'b1;
                    c.mem_to_reg = MrMem;
                    c.dest_sel   = DestRs2;
                    c.use_rs1    = 1'b1;
                end
                OpSt: begin
                    c.dm_write = 1'b1;
                    c.use_rs1  = 1'b1;
                    c.use_rs2  = 1'b1;
                end
                OpMov: begin
                    c.rf_write     = 1'b1;
                    c.rf_dest_addr = 1'b1;
                    c.mem_to_reg   = MrMove;
                    c.dest_sel     = DestRs2;
                    c.use_rs1      = 1'b1;
                end
                OpBr: begin
                    c.jump_or_branch = JbBranch;
                    c.use_rs1        = 1'b1;
                end
                OpJ:     c.jump_or_branch = JbJump;
                OpNop:   c.illegal = 1'b0;
                default: c.illegal = 1'b1;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_control_unit_if.sv
// Instruction-register fields in, datapath control strobes out.
interface pipe_control_unit_if;
    logic [5:0] opcode;
    logic [4:0] rs1_rs;
    logic [4:0] rs2_rd;
    logic [4:0] rd;
    logic       DM_write;
    logic       RF_dest_addr;
    logic       RF_write;
    logic       sli_sri;
    logic       imm_instr;
    logic [1:0] jump_or_branch;
    logic [1:0] mem_to_reg;
    logic       stall;
    logic       flush;
    logic       illegal_op;

    modport master (
        output opcode, rs1_rs, rs2_rd, rd,
        input  DM_write, RF_dest_addr, RF_write, sli_sri, imm_instr,
        input  jump_or_branch, mem_to_reg, stall, flush, illegal_op
    );

    modport slave (
        input  opcode, rs1_rs, rs2_rd, rd,
        output DM_write, RF_dest_addr, RF_write, sli_sri, imm_instr,
        output jump_or_branch, mem_to_reg, stall, flush, illegal_op
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight register-file destinations; flags a RAW hazard
// when a used, nonzero source matches any pending write.
module hazard_scoreboard #(
    parameter int unsigned Depth = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_valid_i,
    input  logic [4:0] push_addr_i,
    input  logic [4:0] src1_addr_i,
    input  logic       src1_used_i,
    input  logic [4:0] src2_addr_i,
    input  logic       src2_used_i,
    output logic       hazard_o
);

    logic [Depth-1:0] valid_q;
    logic [4:0]       addr_q [Depth];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= push_valid_i;
            addr_q[0]  <= push_addr_i;
            for (int unsigned i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    always_comb begin
        hazard_o = 1'b0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (valid_q[i]) begin
                if (src1_used_i && src1_addr_i != 5'd0 && src1_addr_i == addr_q[i]) hazard_o = 1'b1;
                if (src2_used_i && src2_addr_i != 5'd0 && src2_addr_i == addr_q[i]) hazard_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Decode-stage control: opcode decode, RAW stall scoreboard and branch flush FSM.
// Optional ILLEGAL_TRAP_EN: illegal opcodes set a sticky flag and halt until reset.
module pipe_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WB_DELAY     = 3,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic               clk,
    input logic               rst_n,
    pipe_control_unit_if.slave ctrl
);

    localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    ctrl_t           dec;
    logic [4:0]      dest_addr;
    logic            in_run, hazard, issue, push_valid, halted, trap;

    assign dec    = decode(ctrl.opcode);
    assign in_run = (state_q == StRun);

    always_comb begin
        dest_addr = 5'd0;
        case (dec.dest_sel)
            DestRd:  dest_addr = ctrl.rd;
            DestRs2: dest_addr = ctrl.rs2_rd;
            default: dest_addr = 5'd0;
        endcase
    end

    hazard_scoreboard #(
        .Depth (WB_DELAY)
    ) u_scoreboard (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .push_valid_i (push_valid),
        .push_addr_i  (dest_addr),
        .src1_addr_i  (ctrl.rs1_rs),
        .src1_used_i  (dec.use_rs1 & in_run),
        .src2_addr_i  (ctrl.rs2_rd),
        .src2_used_i  (dec.use_rs2 & in_run),
        .hazard_o     (hazard)
    );

    // Only an unstalled instruction in RUN reaches the datapath; all else is a bubble.
    assign issue      = rst_n & in_run & ~hazard;
    assign push_valid = issue & dec.rf_write & (dest_addr != 5'd0);

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    assign trap   = issue & dec.illegal;
    assign halted = (state_q == StHalt);

    always_ff @(posedge clk) begin
        if (!rst_n) illegal_q <= 1'b0;
        else if (trap) illegal_q <= 1'b1;
    end

    assign ctrl.illegal_op = rst_n & illegal_q;
`else
    logic unused_illegal;

    assign unused_illegal  = dec.illegal;
    assign trap            = 1'b0;
    assign halted          = 1'b0;
    assign ctrl.illegal_op = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StRun: begin
                if (issue && dec.jump_or_branch != JbSeq) begin
                    state_d = StFlush;
                    cnt_d   = CntW'(FLUSH_CYCLES - 1);
                end else if (trap) begin
                    state_d = StHalt;
                end
            end
            StFlush: begin
                if (cnt_q == '0) state_d = StRun;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ctrl.DM_write       = issue & dec.dm_write;
    assign ctrl.RF_dest_addr   = issue & dec.rf_dest_addr;
    assign ctrl.RF_write       = issue & dec.rf_write;
    assign ctrl.sli_sri        = issue & dec.sli_sri;
    assign ctrl.imm_instr      = issue & dec.imm_instr;
    assign ctrl.jump_or_branch = issue ? dec.jump_or_branch : JbSeq;
    assign ctrl.mem_to_reg     = issue ? dec.mem_to_reg : MrAlu;
    assign ctrl.stall          = rst_n & ((in_run & hazard) | halted);
    assign ctrl.flush          = rst_n & (state_q == StFlush);

endmodule
